// File: rtl/matvec_pkg.sv
// Shared types and field layout for the 2x2 matrix-vector sequencer.
//   ELEM_W / ACC_W : element and result widths (fixed).
//   state_e        : sequencer states IDLE / MAC / PUSH.
//   *_LSB          : bit positions of matrix, vector and result fields.
package matvec_pkg;
  localparam int ELEM_W = 2;
  localparam int ACC_W  = 2 * ELEM_W + 1;
  localparam int MAT_W  = 4 * ELEM_W;
  localparam int VEC_W  = 2 * ELEM_W;
  localparam int RES_W  = 2 * ACC_W;

  localparam int A00_LSB = 0;
  localparam int A01_LSB = 2;
  localparam int A10_LSB = 4;
  localparam int A11_LSB = 6;
  localparam int X0_LSB  = 0;
  localparam int X1_LSB  = 2;
  localparam int Y0_LSB  = 0;
  localparam int Y1_LSB  = ACC_W;

  typedef enum logic [1:0] {IDLE, MAC, PUSH} state_e;

  function automatic logic [ELEM_W-1:0] mat_elem(input logic [MAT_W-1:0] m, input int lsb);
    return m[lsb +: ELEM_W];
  endfunction
endpackage

// File: rtl/matvec_sequencer_result_fifo.sv
// result_fifo: synchronous FIFO, first-word fall-through head output.
//   push/wdata : write when not full, or when full and popping the same edge.
//   pop        : advance head when not empty.
//   full/empty : from extended-pointer compare (MSB distinguishes wrap).
//   rdata      : current head word (storage is registered; no write bypass).
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head being popped this edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d = wr_q + PTR_ONE;
    end
    if (do_pop) rd_d = rd_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/matvec_sequencer.sv
// matvec_sequencer: y = A*x for a 2x2 matrix of 2-bit elements, one shared
// 2x2-bit multiplier, four MAC steps per vector, results queued in a FIFO.
//   in_data/in_is_mat/in_valid/in_ready : matrix or vector word in.
//   out_data/out_valid/out_ready        : {y1,y0} result out.
//   busy       : a vector is in flight.
//   mat_loaded : a matrix has been loaded since reset.
module matvec_sequencer
  import matvec_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [MAT_W-1:0] in_data,
  input  logic             in_is_mat,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [RES_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             mat_loaded
);
  state_e              state_q, state_d;
  logic [1:0]          step_q, step_d;
  logic [MAT_W-1:0]    mat_q, mat_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [ACC_W-1:0]    acc0_q, acc0_d, acc1_q, acc1_d;
  logic                mat_loaded_q, mat_loaded_d;
  logic [ELEM_W-1:0]   op_a, op_x;
  logic [2*ELEM_W-1:0] prod;
  logic [ACC_W-1:0]    prod_x;
  logic                accept, push, pop, full, empty;

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mat_loaded = mat_loaded_q;
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign accept     = in_valid && in_ready;

  // Operand select for the single multiplier, driven by the MAC step.
  always_comb begin
    op_a = '0;
    op_x = '0;
    case (step_q)
      2'd0: begin op_a = mat_elem(mat_q, A00_LSB); op_x = vec_q[X0_LSB +: ELEM_W]; end
      2'd1: begin op_a = mat_elem(mat_q, A01_LSB); op_x = vec_q[X1_LSB +: ELEM_W]; end
      2'd2: begin op_a = mat_elem(mat_q, A10_LSB); op_x = vec_q[X0_LSB +: ELEM_W]; end
      default: begin op_a = mat_elem(mat_q, A11_LSB); op_x = vec_q[X1_LSB +: ELEM_W]; end
    endcase
  end

  assign prod   = {{ELEM_W{1'b0}}, op_a} * {{ELEM_W{1'b0}}, op_x};
  assign prod_x = {1'b0, prod};

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    mat_d        = mat_q;
    vec_d        = vec_q;
    acc0_d       = acc0_q;
    acc1_d       = acc1_q;
    mat_loaded_d = mat_loaded_q;
    push         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_is_mat) begin
            mat_d        = in_data;
            mat_loaded_d = 1'b1;
          end else begin
            vec_d   = in_data[VEC_W-1:0];
            acc0_d  = '0;
            acc1_d  = '0;
            step_d  = 2'd0;
            state_d = MAC;
          end
        end
      end
      MAC: begin
        step_d = step_q + 2'd1;
        case (step_q)
          2'd0: acc0_d = prod_x;
          2'd1: acc0_d = acc0_q + prod_x;
          2'd2: acc1_d = prod_x;
          default: begin
            acc1_d  = acc1_q + prod_x;
            state_d = PUSH;
          end
        endcase
      end
      PUSH: begin
        if (!full || pop) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      mat_q        <= '0;
      vec_q        <= '0;
      acc0_q       <= '0;
      acc1_q       <= '0;
      mat_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      mat_q        <= mat_d;
      vec_q        <= vec_d;
      acc0_q       <= acc0_d;
      acc1_q       <= acc1_d;
      mat_loaded_q <= mat_loaded_d;
    end
  end

  result_fifo #(.DEPTH(FIFO_DEPTH), .W(RES_W)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .wdata  ({acc1_q, acc0_q}),
    .pop    (pop),
    .full   (full),
    .empty  (empty),
    .rdata  (out_data)
  );
endmodule

// File: tb/tb_matvec_sequencer.sv
module tb_matvec_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_is_mat = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       mat_loaded;

  always #5 clk = ~clk;

  matvec_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_is_mat(in_is_mat),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .mat_loaded(mat_loaded)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: matrix, count of cycles until the block is idle again,
  // the pending result and a queue of results waiting to drain.
  logic [7:0] m_mat = '0;
  bit         m_loaded = 0;
  int         busy_cnt = 0;
  logic [9:0] pend = '0;
  logic [9:0] q[$];

  function automatic logic [9:0] ref_y(input logic [7:0] a, input logic [7:0] v);
    int y0, y1;
    y0 = int'(a[1:0]) * int'(v[1:0]) + int'(a[3:2]) * int'(v[3:2]);
    y1 = int'(a[5:4]) * int'(v[1:0]) + int'(a[7:6]) * int'(v[3:2]);
    return 10'(y1 * 32 + y0);
  endfunction

  task automatic model_clear();
    m_mat = '0; m_loaded = 0; busy_cnt = 0; pend = '0; q.delete();
  endtask

  task automatic compare_all();
    chk("in_ready", 32'(in_ready), 32'(busy_cnt == 0));
    chk("busy", 32'(busy), 32'(busy_cnt != 0));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("mat_loaded", 32'(mat_loaded), 32'(m_loaded));
    if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic cycle(input logic iv, input logic im, input logic [7:0] d, input logic ordy);
    bit idle, pop, do_push;
    in_valid = iv; in_is_mat = im; in_data = d; out_ready = ordy;
    idle    = (busy_cnt == 0);
    pop     = (q.size() != 0) && ordy;
    do_push = (busy_cnt == 1) && ((q.size() < DEPTH) || pop);
    if (pop) void'(q.pop_front());
    if (do_push) begin
      q.push_back(pend);
      busy_cnt = 0;
    end else if (busy_cnt > 1) busy_cnt--;
    if (idle && iv) begin
      if (im) begin m_mat = d; m_loaded = 1; end
      else begin pend = ref_y(m_mat, d); busy_cnt = 5; end
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_cycles(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, ordy);
  endtask

  // Hold a word valid until accepted (bounded).
  task automatic send(input logic im, input logic [7:0] d, input logic ordy);
    for (int i = 0; i < 50; i++) begin
      bit acc;
      acc = (busy_cnt == 0);
      cycle(1'b1, im, d, ordy);
      if (acc) return;
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    in_valid = 0; in_is_mat = 0; in_data = '0; out_ready = 0;
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int waited;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mat_loaded", 32'(mat_loaded), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // No matrix loaded: zero result
    send(1'b0, 8'h0F, 1'b0);
    idle_cycles(5, 1'b0);
    chk("nomat_valid", 32'(out_valid), 32'd1);
    chk("nomat_data", 32'(out_data), 32'h000);
    chk("nomat_loaded", 32'(mat_loaded), 32'd0);
    idle_cycles(1, 1'b1);

    // Basic compute with latency check
    do_reset();
    send(1'b1, 8'hE7, 1'b0);
    send(1'b0, 8'h0E, 1'b0);
    idle_cycles(4, 1'b0);
    chk("basic_not_yet", 32'(out_valid), 32'd0);
    idle_cycles(1, 1'b0);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'h1A9);
    idle_cycles(1, 1'b1);

    // Max values, upper vector bits set
    send(1'b1, 8'hFF, 1'b0);
    send(1'b0, 8'hFF, 1'b0);
    idle_cycles(5, 1'b0);
    chk("max_data", 32'(out_data), 32'h252);
    idle_cycles(1, 1'b1);

    // Matrix reload while busy: held off, result uses old matrix
    send(1'b1, 8'hE7, 1'b0);
    send(1'b0, 8'h0E, 1'b0);
    waited = 0;
    while (busy_cnt != 0 && waited < 20) begin
      cycle(1'b1, 1'b1, 8'h55, 1'b0);
      chk("reload_held", 32'(mat_loaded && in_ready), 32'(busy_cnt == 0));
      waited++;
    end
    cycle(1'b1, 1'b1, 8'h55, 1'b0);
    chk("reload_wait", 32'(waited), 32'd5);
    send(1'b0, 8'h0F, 1'b0);
    idle_cycles(5, 1'b0);
    chk("reload_old", 32'(out_data), 32'h1A9);
    idle_cycles(1, 1'b1);
    chk("reload_new", 32'(out_data), 32'h0C6);
    idle_cycles(1, 1'b1);

    // Backpressure: 5 vectors into a 4-deep FIFO
    do_reset();
    send(1'b1, 8'(($urandom)), 1'b0);
    for (int i = 0; i < 5; i++) send(1'b0, 8'($urandom), 1'b0);
    idle_cycles(10, 1'b0);
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_busy", 32'(busy), 32'd1);
    idle_cycles(1, 1'b1);
    chk("bp_unstall", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) idle_cycles(1, 1'b1);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 3) != 0, ($urandom % 4) == 0, 8'($urandom), ($urandom % 3) != 0);

    // Asynchronous reset mid-MAC with a non-empty FIFO
    do_reset();
    send(1'b1, 8'hE7, 1'b0);
    send(1'b0, 8'h0E, 1'b0);
    idle_cycles(5, 1'b0);
    send(1'b0, 8'h0F, 1'b0);
    idle_cycles(2, 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_mat_loaded", 32'(mat_loaded), 32'd0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/matvec_sequencer.md
Name: matvec_sequencer

Overview:
Sequencer for the 2x2-by-2x1 matrix-vector multiply with 2-bit elements and 5-bit results. It loads a matrix, accepts a stream of vectors over a valid/ready input, and computes each result on one shared 2x2-bit multiplier. Each product is accumulated over 4 MAC cycles. Results go into a small FIFO that drains over a valid/ready output. The block sits between the byte-wide input pins and the 10-bit result path.

Parameters:
FIFO_DEPTH, 4, result FIFO entries (power of 2, min 2)
ELEM_W, 2, element width (fixed at 2; not user-overridable)
ACC_W, 5, result element width = 2*ELEM_W+1

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
in_data  in  8  matrix word or vector word
in_is_mat  in  1  1: in_data is a matrix, 0: in_data is a vector
in_valid  in  1  input word valid
in_ready  out  1  block accepts a word this cycle
out_data  out  10  [4:0]=y0, [9:5]=y1
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head this cycle
busy  out  1  vector in flight (not IDLE)
mat_loaded  out  1  a matrix has been loaded since reset

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: all outputs 0 except in_ready=1. Matrix regs = 0, accumulators = 0, FIFO empty, state IDLE.
- Reset mid-operation: in-flight vector and FIFO contents are discarded, and the matrix is cleared.
- Matrix packing: a00=[1:0], a01=[3:2], a10=[5:4], a11=[7:6].
- Vector packing: x0=[1:0], x1=[3:2]. Bits [7:4] are ignored.
- Result: y0=a00*x0+a01*x1, y1=a10*x0+a11*x1. The maximum is 18, so no overflow in 5 bits. No saturation logic.
- in_ready = (state==IDLE).
- Accept = in_valid && in_ready.
- Matrix accept: load the matrix regs on that edge, set mat_loaded, stay in IDLE. Back-to-back matrix loads are allowed every cycle.
- Vector accept on edge T: latch x0/x1, clear the accumulators, go to MAC with step=0.
- Vector before any matrix load: computes with the zero matrix and yields result 0. Not an error.
- MAC state, edges T+1..T+4, one product per step, one multiplier:
  - step0: acc0 = a00*x0
  - step1: acc0 += a01*x1
  - step2: acc1 = a10*x0
  - step3: acc1 += a11*x1, then go to PUSH
- PUSH state:
  - Write {acc1,acc0} into the FIFO when (!full || pop_this_cycle), then go to IDLE.
  - With no stall this is edge T+5, so out_valid is visible after T+5 if the FIFO was empty.
  - If the FIFO is full and there is no pop, stay in PUSH (stall). in_ready stays 0.
- Matrix stability: the matrix regs cannot change while busy, since in_ready=0.
- Accept-to-accept throughput is 6 cycles per vector.
- FIFO pop = out_valid && out_ready. out_data shows the head (registered read, first-word fall-through).
- Simultaneous push and pop:
  - When full, both are allowed and occupancy is unchanged.
  - When empty, the pushed word appears the cycle after; no bypass.
- Pointer wrap-around: pointers are log2(FIFO_DEPTH)+1 bits. full/empty come from the MSB compare.
- in_valid with in_is_mat=1 while busy is not accepted; the source holds it.
- in_data and in_is_mat are sampled only on accept.
- busy = (state != IDLE).

Decomposition:
- Package matvec_pkg holds: ELEM_W, ACC_W; the state enum IDLE/MAC/PUSH; the bit-field positions for matrix, vector and result packing.
- One sub-module, result_fifo: a parameterised synchronous FIFO with push, pop, full, empty and a head-data output.
- The sequencer FSM, the shared multiplier and the accumulators stay in matvec_sequencer.

Test Plan:
- Reset then idle:
  - Required: in_ready=1, out_valid=0, busy=0, mat_loaded=0.
  - Assert reset_n low mid-MAC: busy drops immediately (asynchronously); the FIFO empties.
- Basic compute:
  - Stimulus: matrix 0xE7 (a00=3, a01=1, a10=2, a11=3), then vector 0x0E (x0=2, x1=3).
  - Required: out_data=0x1A9 (y0=9, y1=13), with out_valid rising after edge T+5 (T = vector accept edge).
- Max values:
  - Stimulus: matrix 0xFF, vector 0x0F.
  - Required: out_data=0x252 (18,18). Upper vector bits 0xF0 set give the same result.
- Backpressure:
  - Stimulus: out_ready=0, push 5 vectors with FIFO_DEPTH=4.
  - Required: the 5th stalls in PUSH with in_ready=0. Raising out_ready for 1 cycle pops one and pushes the stalled one that same edge; order is preserved.
- No matrix loaded:
  - Stimulus: vector 0x0F right after reset.
  - Required: out_data=0x000, mat_loaded=0.
- Matrix reload:
  - Stimulus: matrix A, vector v, matrix B presented while busy.
  - Required: B is held off until IDLE. The result uses A, and the next vector uses B.
